// File: rtl/cache_ctrl_nway_pkg.sv
// cache_types: shared types and helpers for the N-way cache controller.
//   cache_state_t : controller FSM state encoding
//   way_w()       : way-select width for a given associativity
//   plru_victim() : walk a heap-ordered tree-PLRU word to its victim way
//   plru_update() : point every node on a way's path away from that way
// PLRU words are handled at the 8-way maximum (7 bits). Narrower caches
// zero-extend their bits and use only the low WAYS-1 bits of the result.
package cache_types;

  typedef enum logic [1:0] {
    s_hit        = 2'd0,
    s_write_back = 2'd1,
    s_fill       = 2'd2
  } cache_state_t;

  localparam int WAY_MAX_W = 3;

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  // Node n has children 2n+1 (lower half) and 2n+2 (upper half).
  // A node bit of 0 sends the walk to the lower half.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int ways);
    logic [2:0] node;
    logic [2:0] way;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < WAY_MAX_W; lvl++) begin
      if (lvl < way_w(ways)) begin
        way  = {way[1:0], bits[node]};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
      end
    end
    return way;
  endfunction

  function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                             input int ways);
    logic [6:0] nb;
    logic [2:0] node;
    logic [2:0] path;
    logic       dir;
    nb   = bits;
    node = '0;
    // Left-align the way number so its MSB picks the branch at the root.
    path = way << (WAY_MAX_W - way_w(ways));
    for (int lvl = 0; lvl < WAY_MAX_W; lvl++) begin
      if (lvl < way_w(ways)) begin
        dir      = path[2];
        nb[node] = ~dir;
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
        path     = path << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_plru_array.sv
// plru_array: per-set tree pseudo-LRU storage.
//   clk, rst_n    : clock, async active-low clear of every set
//   index         : set being looked up / updated
//   victim        : PLRU victim way of the indexed set
//   access_valid  : update the indexed set for access_way this cycle
//   access_way    : way that was just accessed
module plru_array
  import cache_types::*;
#(
  parameter int WAYS  = 2,
  parameter int IDX_W = 3,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] index,
  output logic [WAY_W-1:0] victim,
  input  logic             access_valid,
  input  logic [WAY_W-1:0] access_way
);

  localparam int SETS = 2 ** IDX_W;

  logic [WAYS-2:0] plru_q [SETS];
  logic [6:0]      cur_bits;
  logic [6:0]      upd_bits;
  logic            unused_upd_hi;

  assign cur_bits      = 7'(plru_q[index]);
  assign upd_bits      = plru_update(cur_bits, 3'(access_way), WAYS);
  assign victim        = WAY_W'(plru_victim(cur_bits, WAYS));
  assign unused_upd_hi = ^upd_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (access_valid) begin
      plru_q[index] <= upd_bits[WAYS-2:0];
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: write-back, write-allocate controller for an N-way
// set-associative cache datapath.
//   clk, rst_n                : clock, async active-low reset
//   mem_read/mem_write        : CPU request, held until mem_resp
//   mem_index                 : set index of the CPU address
//   mem_resp                  : CPU request complete
//   way_hit/way_valid/way_dirty : per-way status for mem_index
//   pmem_read/pmem_write      : physical memory request, held to pmem_resp
//   pmem_resp                 : physical memory transfer complete
//   w_data/w_tag/w_valid/w_dirty : one-hot array load enables
//   valid_in/dirty_in         : bit values loaded on w_valid/w_dirty
//   datain_sel                : 0 CPU write merge, 1 pmem line
//   pmem_addr_sel             : 0 CPU tag/index, 1 victim tag/index
//   way_sel                   : way routed through the datapath read mux
//
// state        | meaning
// s_hit        | idle / serving hits; a miss picks and latches the victim
// s_write_back | writing the dirty victim line to pmem
// s_fill       | reading the missing line from pmem into the victim way
module cache_ctrl_nway
  import cache_types::*;
#(
  parameter int WAYS  = 2,
  parameter int IDX_W = 3,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [IDX_W-1:0] mem_index,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  way_hit,
  input  logic [WAYS-1:0]  way_valid,
  input  logic [WAYS-1:0]  way_dirty,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [WAYS-1:0]  w_data,
  output logic [WAYS-1:0]  w_tag,
  output logic [WAYS-1:0]  w_valid,
  output logic [WAYS-1:0]  w_dirty,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             datain_sel,
  output logic             pmem_addr_sel,
  output logic [WAY_W-1:0] way_sel
);

  cache_state_t     state_q, state_d;
  logic [WAY_W-1:0] victim_q;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, miss_victim;
  logic             hit_any, inv_any, req, miss, access_valid;

  assign req          = mem_read | mem_write;
  assign hit_any      = |way_hit;
  assign inv_any      = ~&way_valid;
  assign miss         = (state_q == s_hit) && req && !hit_any;
  assign access_valid = (state_q == s_hit) && req && hit_any;
  // Empty ways are always filled before anything is evicted.
  assign miss_victim  = inv_any ? inv_way : plru_way;

  // Lowest index wins for both the (illegal) multi-hot hit and invalid search.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i])    hit_way = WAY_W'(i);
      if (!way_valid[i]) inv_way = WAY_W'(i);
    end
  end

  plru_array #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W)
  ) u_plru (
    .clk          (clk),
    .rst_n        (rst_n),
    .index        (mem_index),
    .victim       (plru_way),
    .access_valid (access_valid),
    .access_way   (hit_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= s_hit;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) victim_q <= miss_victim;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_hit: begin
        if (miss) begin
          if (way_valid[miss_victim] && way_dirty[miss_victim]) state_d = s_write_back;
          else                                                  state_d = s_fill;
        end
      end
      s_write_back: if (pmem_resp) state_d = s_fill;
      s_fill:       if (pmem_resp) state_d = s_hit;
      default:      state_d = s_hit;
    endcase
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    w_data        = '0;
    w_tag         = '0;
    w_valid       = '0;
    w_dirty       = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    case (state_q)
      s_hit: begin
        if (access_valid) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          // Write wins when both request strobes are up.
          if (mem_write) begin
            w_data[hit_way]  = 1'b1;
            w_dirty[hit_way] = 1'b1;
            dirty_in         = 1'b1;
          end
        end
      end
      s_write_back: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
      end
      s_fill: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          w_data[victim_q]  = 1'b1;
          w_tag[victim_q]   = 1'b1;
          w_valid[victim_q] = 1'b1;
          w_dirty[victim_q] = 1'b1;
          valid_in          = 1'b1;
          datain_sel        = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
module tb_cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 2-way instance
  logic       a_rd, a_wr, a_presp;
  logic [2:0] a_idx;
  logic [1:0] a_hit, a_vld, a_drt;
  logic       a_resp, a_pr, a_pw, a_vi, a_di, a_ds, a_pas;
  logic [1:0] a_wd, a_wt, a_wv, a_wdy;
  logic [0:0] a_ws;

  // 4-way instance
  logic       b_rd, b_wr, b_presp;
  logic [2:0] b_idx;
  logic [3:0] b_hit, b_vld, b_drt;
  logic       b_resp, b_pr, b_pw, b_vi, b_di, b_ds, b_pas;
  logic [3:0] b_wd, b_wt, b_wv, b_wdy;
  logic [1:0] b_ws;

  cache_ctrl_nway #(.WAYS(2), .IDX_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr), .mem_index(a_idx),
    .mem_resp(a_resp), .way_hit(a_hit), .way_valid(a_vld), .way_dirty(a_drt),
    .pmem_read(a_pr), .pmem_write(a_pw), .pmem_resp(a_presp),
    .w_data(a_wd), .w_tag(a_wt), .w_valid(a_wv), .w_dirty(a_wdy),
    .valid_in(a_vi), .dirty_in(a_di), .datain_sel(a_ds), .pmem_addr_sel(a_pas),
    .way_sel(a_ws)
  );

  cache_ctrl_nway #(.WAYS(4), .IDX_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr), .mem_index(b_idx),
    .mem_resp(b_resp), .way_hit(b_hit), .way_valid(b_vld), .way_dirty(b_drt),
    .pmem_read(b_pr), .pmem_write(b_pw), .pmem_resp(b_presp),
    .w_data(b_wd), .w_tag(b_wt), .w_valid(b_wv), .w_dirty(b_wdy),
    .valid_in(b_vi), .dirty_in(b_di), .datain_sel(b_ds), .pmem_addr_sel(b_pas),
    .way_sel(b_ws)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rd = 0; a_wr = 0; a_presp = 0; a_idx = 0; a_hit = 0; a_vld = 0; a_drt = 0;
    b_rd = 0; b_wr = 0; b_presp = 0; b_idx = 0; b_hit = 0; b_vld = 0; b_drt = 0;
    rst_n = 0;
    #12;
    chk("rst_outs_2way", 32'({a_resp, a_pr, a_pw, a_wd, a_wt, a_wv, a_wdy,
                              a_vi, a_di, a_ds, a_pas, a_ws}), 0);
    chk("rst_outs_4way", 32'({b_resp, b_pr, b_pw, b_wd, b_wt, b_wv, b_wdy,
                              b_vi, b_di, b_ds, b_pas, b_ws}), 0);
    rst_n = 1;

    // 2-way: read miss to empty set 3, 4-cycle fill into way 0
    step(); a_idx = 3; a_rd = 1; #1;
    chk("t1_miss_resp", a_resp, 0);
    chk("t1_miss_pr", a_pr, 0);
    for (int i = 0; i < 4; i++) begin
      step(); a_presp = (i == 3); #1;
      chk($sformatf("t1_pr_held_%0d", i), a_pr, 1);
      chk($sformatf("t1_addr_sel_%0d", i), a_pas, 0);
    end
    chk("t1_w_data", a_wd, 2'b01);
    chk("t1_w_tag", a_wt, 2'b01);
    chk("t1_w_valid", a_wv, 2'b01);
    chk("t1_w_dirty", a_wdy, 2'b01);
    chk("t1_valid_in", a_vi, 1);
    chk("t1_dirty_in", a_di, 0);
    chk("t1_datain_sel", a_ds, 1);
    step(); a_presp = 0; a_hit = 2'b01; a_vld = 2'b01; #1;
    chk("t1_hit_resp", a_resp, 1);
    chk("t1_hit_pr", a_pr, 0);
    chk("t1_pulse_done", a_wd, 0);
    step(); a_rd = 0; a_hit = 0; #1;
    chk("t1_idle_resp", a_resp, 0);

    // 4-way: set 5 all valid clean, PLRU 000 -> victim 0
    step(); b_idx = 5; b_vld = 4'hf; b_drt = 0; b_hit = 0; b_rd = 1; #1;
    chk("t2_miss_resp", b_resp, 0);
    step(); #1;
    chk("t2_fill_pr", b_pr, 1);
    chk("t2_victim0", b_ws, 0);
    step(); b_presp = 1; #1;
    chk("t2_w_valid0", b_wv, 4'b0001);
    step(); b_presp = 0; b_hit = 4'b0001; #1;
    chk("t2_hit0_resp", b_resp, 1);
    chk("t2_hit0_sel", b_ws, 0);
    step(); b_hit = 4'b0100; #1;
    chk("t2_hit2_resp", b_resp, 1);
    chk("t2_hit2_sel", b_ws, 2);
    step(); b_hit = 0; #1;
    chk("t2_miss2_resp", b_resp, 0);
    step(); #1;
    chk("t2_victim1", b_ws, 1);
    chk("t2_fill2_pr", b_pr, 1);
    step(); b_presp = 1; #1;
    chk("t2_w_data1", b_wd, 4'b0010);
    step(); b_presp = 0; b_hit = 4'b0010; #1;
    chk("t2_hit1_resp", b_resp, 1);

    // read hit way 0, then write (with read also up) hit way 2
    step(); b_hit = 4'b0001; #1;
    chk("t3_hit0_resp", b_resp, 1);
    step(); b_wr = 1; b_hit = 4'b0100; #1;
    chk("t3_wr_resp", b_resp, 1);
    chk("t3_wr_w_data", b_wd, 4'b0100);
    chk("t3_wr_w_dirty", b_wdy, 4'b0100);
    chk("t3_wr_dirty_in", b_di, 1);
    chk("t3_wr_datain_sel", b_ds, 0);
    chk("t3_wr_w_valid", b_wv, 0);
    chk("t3_wr_w_tag", b_wt, 0);
    chk("t3_wr_way_sel", b_ws, 2);

    // PLRU now points at way 1, which is dirty -> write-back then fill
    step(); b_wr = 0; b_hit = 0; b_drt = 4'b0010; #1;
    chk("t4_miss_resp", b_resp, 0);
    chk("t4_miss_pw", b_pw, 0);
    step(); #1;
    chk("t4_wb_pw", b_pw, 1);
    chk("t4_wb_pr", b_pr, 0);
    chk("t4_wb_addr_sel", b_pas, 1);
    chk("t4_wb_way_sel", b_ws, 1);
    step(); b_presp = 1; #1;
    chk("t4_wb_pw_held", b_pw, 1);
    chk("t4_wb_no_load", b_wd, 0);
    step(); b_presp = 0; #1;
    chk("t4_fill_pr", b_pr, 1);
    chk("t4_fill_pw", b_pw, 0);
    chk("t4_fill_addr_sel", b_pas, 0);
    chk("t4_fill_way_sel", b_ws, 1);
    step(); b_presp = 1; #1;
    chk("t4_fill_w_dirty", b_wdy, 4'b0010);
    chk("t4_fill_w_data", b_wd, 4'b0010);
    chk("t4_fill_dirty_in", b_di, 0);
    chk("t4_fill_valid_in", b_vi, 1);
    step(); b_presp = 0; b_hit = 4'b0010; b_drt = 0; #1;
    chk("t4_hit_resp", b_resp, 1);

    // PLRU points at way 3; dirty -> write-back, reset mid-transfer
    step(); b_hit = 0; b_drt = 4'b1000; #1;
    chk("t5_miss_resp", b_resp, 0);
    step(); #1;
    chk("t5_wb_pw", b_pw, 1);
    chk("t5_wb_way3", b_ws, 3);
    rst_n = 0; #1;
    chk("t5_rst_outs", 32'({b_resp, b_pr, b_pw, b_wd, b_wt, b_wv, b_wdy,
                            b_vi, b_di, b_ds, b_pas, b_ws}), 0);
    step(); rst_n = 1; b_drt = 0; #1;
    chk("t5_after_rst_pw", b_pw, 0);
    chk("t5_after_rst_pr", b_pr, 0);
    step(); #1;
    chk("t5_refill_pr", b_pr, 1);
    chk("t5_plru_cleared", b_ws, 0);
    step(); b_presp = 1; #1;
    chk("t5_w_valid0", b_wv, 4'b0001);
    step(); b_presp = 0; b_hit = 4'b0001; #1;
    chk("t5_hit_resp", b_resp, 1);
    step(); b_rd = 0; b_hit = 0;

    // request dropped mid-fill
    b_idx = 1; b_vld = 0; b_rd = 1; #1;
    chk("t6_miss_resp", b_resp, 0);
    step(); b_rd = 0; #1;
    chk("t6_fill_held", b_pr, 1);
    step(); b_presp = 1; #1;
    chk("t6_w_valid0", b_wv, 4'b0001);
    step(); b_presp = 0; #1;
    chk("t6_no_resp", b_resp, 0);
    chk("t6_idle_pr", b_pr, 0);
    step(); #1;
    chk("t6_still_idle_pr", b_pr, 0);
    chk("t6_still_no_resp", b_resp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
